// File: rtl/cpu_fetch_stream_if.sv
// Fetch record type and the fetch<->bus/decode interface bundle.
// The master modport is the fetch side; the slave modport is the bus/decode/execute side.
package cpu_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [4:0]  inst_rs1;
    logic [4:0]  inst_rs2;
    logic [4:0]  inst_rd;
    logic        strobe;
  } fetch_data_t;
endpackage

interface cpu_fetch_stream_if;
  import cpu_fetch_pkg::*;

  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        i_busy;
  logic        i_jump;
  logic [31:0] i_jump_pc;
  fetch_data_t o_data;
  logic        o_fault;

  modport master (
    output o_bus_request, o_bus_address, o_data, o_fault,
    input  i_bus_ready, i_bus_rdata, i_busy, i_jump, i_jump_pc
  );

  modport slave (
    input  o_bus_request, o_bus_address, o_data, o_fault,
    output i_bus_ready, i_bus_rdata, i_busy, i_jump, i_jump_pc
  );
endinterface

// File: rtl/cpu_fetch_stream.sv
// Instruction fetch producer: reads words, packs them into fetch records and toggles strobe.
// Optional CPU_FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky fault and halts fetch.
module cpu_fetch_stream #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic               i_clock,
  input logic               i_reset_n,
  cpu_fetch_stream_if.master bus
);
  import cpu_fetch_pkg::*;

  typedef enum logic [1:0] {FETCH, HOLD, FLUSH, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  fetch_data_t data_q, data_d;
  logic        fault_q, fault_d;
  logic [31:0] jump_target;
  logic        jump_bad;
  logic [31:0] flush_target;
  fetch_data_t captured;

  assign jump_target = bus.i_jump_pc & 32'hFFFF_FFFC;

`ifdef CPU_FETCH_ALIGN_CHECK_EN
  assign jump_bad = bus.i_jump && (bus.i_jump_pc[1:0] != 2'b00);
`else
  assign jump_bad = 1'b0;
`endif

  assign flush_target = bus.i_jump ? jump_target : pc_q;

  always_comb begin
    captured.pc          = addr_q;
    captured.instruction = bus.i_bus_rdata;
    captured.inst_rs1    = bus.i_bus_rdata[19:15];
    captured.inst_rs2    = bus.i_bus_rdata[24:20];
    captured.inst_rd     = bus.i_bus_rdata[11:7];
    captured.strobe      = ~data_q.strobe;
  end

  // Redirects outrank busy and capture; a read still in flight is drained in FLUSH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: begin
        if (jump_bad) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = HALT;
        end else if (bus.i_jump) begin
          pc_d = jump_target;
          if (req_q && !bus.i_bus_ready) begin
            state_d = FLUSH;
          end else begin
            req_d  = 1'b1;
            addr_d = jump_target;
          end
        end else if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end else if (bus.i_bus_ready) begin
          data_d = captured;
          pc_d   = addr_q + 32'd4;
          if (bus.i_busy) begin
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            addr_d = addr_q + 32'd4;
          end
        end
      end
      HOLD: begin
        if (jump_bad) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (bus.i_jump) begin
          pc_d    = jump_target;
          req_d   = 1'b1;
          addr_d  = jump_target;
          state_d = FETCH;
        end else if (!bus.i_busy) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (jump_bad) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = HALT;
        end else begin
          pc_d = flush_target;
          if (bus.i_bus_ready) begin
            req_d   = 1'b1;
            addr_d  = flush_target;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // All outputs are registered so the first request appears one edge after reset release.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      req_q   <= 1'b0;
      addr_q  <= RESET_VECTOR;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign bus.o_bus_request = req_q;
  assign bus.o_bus_address = addr_q;
  assign bus.o_data        = data_q;
  assign bus.o_fault       = fault_q;
endmodule

// File: tb/tb_cpu_fetch_stream.sv
// Directed-vector bench for cpu_fetch_stream; each vector is the input for one edge
// and the outputs expected just after that edge.
module tb_cpu_fetch_stream;
  import cpu_fetch_pkg::*;

  localparam logic [31:0] INST_A = 32'h00B5_0533;
  localparam logic [31:0] INST_B = 32'h0041_8233;

  typedef struct {
    logic        ready;
    logic        busy;
    logic        jump;
    logic [31:0] jump_pc;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_strobe;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [4:0]  exp_rs1;
    logic [4:0]  exp_rs2;
    logic [4:0]  exp_rd;
  } vec_t;

  logic i_clock = 1'b0;
  logic i_reset_n = 1'b1;
  int   checks_total = 0;
  int   checks_passed = 0;
  vec_t vecs[$];

  cpu_fetch_stream_if bus();

  cpu_fetch_stream #(.RESET_VECTOR(32'h0000_0000)) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic ready, input logic busy, input logic jump,
                               input logic [31:0] jump_pc, input logic [31:0] rdata);
    bus.i_bus_ready = ready;
    bus.i_busy      = busy;
    bus.i_jump      = jump;
    bus.i_jump_pc   = jump_pc;
    bus.i_bus_rdata = rdata;
    @(posedge i_clock);
    #1;
  endtask

  function automatic vec_t mk(input logic ready, input logic busy, input logic jump,
                              input logic [31:0] jump_pc, input logic [31:0] rdata,
                              input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_strobe, input logic [31:0] exp_pc,
                              input logic [31:0] exp_instr, input logic [4:0] exp_rs1,
                              input logic [4:0] exp_rs2, input logic [4:0] exp_rd);
    vec_t v;
    v.ready = ready; v.busy = busy; v.jump = jump; v.jump_pc = jump_pc; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_strobe = exp_strobe;
    v.exp_pc = exp_pc; v.exp_instr = exp_instr;
    v.exp_rs1 = exp_rs1; v.exp_rs2 = exp_rs2; v.exp_rd = exp_rd;
    return v;
  endfunction

  initial begin
    bus.i_bus_ready = 1'b0;
    bus.i_busy      = 1'b0;
    bus.i_jump      = 1'b0;
    bus.i_jump_pc   = '0;
    bus.i_bus_rdata = '0;

    // Back-to-back fetch, wait states, busy hold, redirects, double redirect, address wrap.
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'h4,        1,32'h0,        INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'h8,        0,32'h4,        INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'hC,        1,32'h8,        INST_A,10,11,10));
    vecs.push_back(mk(0,0,0,0,INST_A,            1,32'hC,        1,32'h8,        INST_A,10,11,10));
    vecs.push_back(mk(0,0,0,0,INST_A,            1,32'hC,        1,32'h8,        INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'h10,       0,32'hC,        INST_A,10,11,10));
    vecs.push_back(mk(1,1,0,0,INST_A,            0,32'h0,        1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(0,1,0,0,INST_A,            0,32'h0,        1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(0,1,0,0,INST_A,            0,32'h0,        1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(0,1,0,0,INST_A,            0,32'h0,        1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(0,0,0,0,INST_A,            1,32'h14,       1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(0,0,1,32'h100,INST_A,      1,32'h14,       1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,32'hDEADBEEF,      1,32'h100,      1,32'h10,       INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_B,            1,32'h104,      0,32'h100,      INST_B,3,4,4));
    vecs.push_back(mk(1,0,1,32'h200,32'hCAFEF00D,1,32'h200,      0,32'h100,      INST_B,3,4,4));
    vecs.push_back(mk(1,1,0,0,INST_A,            0,32'h0,        1,32'h200,      INST_A,10,11,10));
    vecs.push_back(mk(0,1,1,32'h300,INST_A,      1,32'h300,      1,32'h200,      INST_A,10,11,10));
    vecs.push_back(mk(0,0,1,32'h400,INST_A,      1,32'h300,      1,32'h200,      INST_A,10,11,10));
    vecs.push_back(mk(0,0,1,32'h500,INST_A,      1,32'h300,      1,32'h200,      INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,32'h12345678,      1,32'h500,      1,32'h200,      INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'h504,      0,32'h500,      INST_A,10,11,10));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,INST_A,1,32'h504,      0,32'h500,      INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'hFFFF_FFFC,0,32'h500,      INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'h0,        1,32'hFFFF_FFFC,INST_A,10,11,10));
    vecs.push_back(mk(1,0,0,0,INST_A,            1,32'h4,        0,32'h0,        INST_A,10,11,10));

    #2 i_reset_n = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    checkOutput("reset req",    32'(bus.o_bus_request), 32'h0);
    checkOutput("reset addr",   bus.o_bus_address,      32'h0);
    checkOutput("reset pc",     bus.o_data.pc,          32'h0);
    checkOutput("reset instr",  bus.o_data.instruction, 32'h0);
    checkOutput("reset strobe", 32'(bus.o_data.strobe), 32'h0);
    checkOutput("reset fault",  32'(bus.o_fault),       32'h0);

    i_reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, INST_A);
    checkOutput("first req",  32'(bus.o_bus_request), 32'h1);
    checkOutput("first addr", bus.o_bus_address,      32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ready, vecs[i].busy, vecs[i].jump, vecs[i].jump_pc, vecs[i].rdata);
      checkOutput($sformatf("vec%0d req", i), 32'(bus.o_bus_request), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        checkOutput($sformatf("vec%0d addr", i), bus.o_bus_address, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d strobe", i), 32'(bus.o_data.strobe), 32'(vecs[i].exp_strobe));
      checkOutput($sformatf("vec%0d pc", i), bus.o_data.pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d instr", i), bus.o_data.instruction, vecs[i].exp_instr);
      checkOutput($sformatf("vec%0d fields", i),
                  {17'h0, bus.o_data.inst_rs1, bus.o_data.inst_rs2, bus.o_data.inst_rd},
                  {17'h0, vecs[i].exp_rs1, vecs[i].exp_rs2, vecs[i].exp_rd});
    end

`ifdef CPU_FETCH_ALIGN_CHECK_EN
    applyStimulus(0, 0, 1, 32'h0000_0602, INST_A);
    checkOutput("align fault", 32'(bus.o_fault),       32'h1);
    checkOutput("align req",   32'(bus.o_bus_request), 32'h0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 0, INST_A);
      checkOutput($sformatf("halt%0d req", i), 32'(bus.o_bus_request), 32'h0);
      checkOutput($sformatf("halt%0d strobe", i), 32'(bus.o_data.strobe), 32'h0);
    end
    checkOutput("halt fault sticky", 32'(bus.o_fault), 32'h1);
    #3 i_reset_n = 1'b0;
    #1;
    checkOutput("fault cleared", 32'(bus.o_fault), 32'h0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, INST_A);
    checkOutput("restart req", 32'(bus.o_bus_request), 32'h1);
`else
    applyStimulus(0, 0, 1, 32'h0000_0603, INST_A);
    checkOutput("misalign flush req",  32'(bus.o_bus_request), 32'h1);
    checkOutput("misalign flush addr", bus.o_bus_address,      32'h4);
    applyStimulus(1, 0, 0, 0, INST_A);
    checkOutput("misalign target", bus.o_bus_address, 32'h600);
    checkOutput("misalign fault",  32'(bus.o_fault),  32'h0);
    checkOutput("misalign strobe", 32'(bus.o_data.strobe), 32'h0);
`endif

    // Reset asserted mid-cycle with a request outstanding must drop everything at once.
    #3 i_reset_n = 1'b0;
    #1;
    checkOutput("midreset req",    32'(bus.o_bus_request), 32'h0);
    checkOutput("midreset addr",   bus.o_bus_address,      32'h0);
    checkOutput("midreset pc",     bus.o_data.pc,          32'h0);
    checkOutput("midreset strobe", 32'(bus.o_data.strobe), 32'h0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, INST_A);
    checkOutput("post reset req",  32'(bus.o_bus_request), 32'h1);
    checkOutput("post reset addr", bus.o_bus_address,      32'h0);
    applyStimulus(1, 0, 0, 0, INST_B);
    checkOutput("post reset strobe", 32'(bus.o_data.strobe), 32'h1);
    checkOutput("post reset instr",  bus.o_data.instruction, INST_B);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/cpu_fetch_stream.md
# cpu_fetch_stream

Instruction fetch producer for the CPU pipeline. Issues word reads on the instruction bus, packs each returned word into a `fetch_data_t` record, and hands it to the decode stage by toggling `strobe`. Handles redirects from execute, downstream back-pressure, and outstanding-transaction flushing. It is the upstream end of the fetch→decode interface.

## Interface
Parameters:
- `RESET_VECTOR`, `32'h0000_0000`: first PC fetched after reset release.

Ports:
- `i_clock`  in  1  single clock; all state changes on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `o_bus_request`  out  1  instruction read request; held until `i_bus_ready`.
- `o_bus_address`  out  32  word address of the request; stable while request high.
- `i_bus_ready`  in  1  read complete; `i_bus_rdata` valid this cycle.
- `i_bus_rdata`  in  32  instruction word.
- `i_busy`  in  1  decode cannot accept a new record; fetch holds output.
- `i_jump`  in  1  single-cycle redirect pulse from execute.
- `i_jump_pc`  in  32  redirect target, sampled when `i_jump`=1.
- `o_data`  out  `fetch_data_t`  pc, instruction, inst_rs1, inst_rs2, inst_rd, strobe.
- `o_fault`  out  1  sticky fault (see Configuration).

## Operation
- Field extraction on capture: `inst_rs1`=instr[19:15], `inst_rs2`=instr[24:20], `inst_rd`=instr[11:7]; `pc`=address the word was read from.
- `strobe` toggles exactly once per delivered record; decode detects new data by edge.
- Internal `pc` register: next fetch address, advances by 4 (mod 2^32, wraps FFFF_FFFC→0000_0000).
- States:
  - `FETCH`: request high at `pc`. On `i_bus_ready`: capture record, toggle strobe, `pc`+=4; stay in `FETCH` if `i_busy`=0, else go `HOLD`.
  - `HOLD`: request low, record held. When `i_busy`=0 → `FETCH`.
  - `FLUSH`: request still high for the outstanding read. On `i_bus_ready`: discard data (no strobe toggle) → `FETCH` at redirect PC.
  - `HALT`: fault only; request low forever until reset.
- Redirect (`i_jump`=1): `pc`←`i_jump_pc`. In `FETCH` with request outstanding and no `i_bus_ready` in the same cycle → `FLUSH`. Same cycle as `i_bus_ready` → data discarded, go `FETCH` at target. In `HOLD` → `FETCH` at target; held record is not re-delivered.
- The redirect takes priority over `i_busy` and over capture.
- Only the latest `i_jump` wins; a second pulse during `FLUSH` overwrites the target.

## Timing
- Reset (async assert): `o_bus_request`=0, `o_bus_address`=`RESET_VECTOR`, `o_data`=0 (strobe=0), `o_fault`=0, state `FETCH`, `pc`=`RESET_VECTOR`.
- First request is high on the first rising edge after `i_reset_n` deasserts (registered output).
- Bus: zero-wait-state ready gives back-to-back fetches, one record per cycle. The request stays high across the ready edge with the next address.
- Latency: `i_bus_ready` at edge N → `o_data` and strobe toggle visible after edge N.
- Redirect: `i_jump` at edge N → request at `i_jump_pc` after edge N, or after the flushed ready.
- Reset mid-transaction: abandon immediately. The bus must tolerate request drop.

## Configuration
- `CPU_FETCH_ALIGN_CHECK_EN` defined: if `i_jump` carries `i_jump_pc[1:0]`≠0, set `o_fault`=1 (sticky), enter `HALT`, and deliver no further records.
- Not defined: low address bits are ignored. `pc` is forced to `{i_jump_pc[31:2],2'b00}`, and `o_fault` is tied 0.

## Test plan
- Reset release, RESET_VECTOR=0, ready every cycle, rdata=`32'h00B50533` → records at pc 0,4,8 on consecutive cycles; rs1=10, rs2=11, rd=10; strobe 1,0,1.
- Ready with 3-cycle wait → address 0 held 3 cycles; one strobe toggle only.
- `i_busy`=1 for 4 cycles after the first record → request low; o_data unchanged; fetch resumes at pc 4 after busy drops.
- `i_jump` to `32'h0000_0100` during an outstanding read to 8 → read at 8 completes with no strobe toggle; next request at 0x100; next record pc=0x100.
- pc=`FFFF_FFFC` → the following request is at `0000_0000`.
- With `CPU_FETCH_ALIGN_CHECK_EN`, jump to `32'h0000_0102` → o_fault=1 next edge; request stays 0 for 20 cycles; deasserting `i_reset_n` clears the fault.
